writeback_forward_unit: RTL and testbench
=========================================

Name: writeback_forward_unit

Overview:
- Back end of the decode-stage feedback interface: the stage that drives regfile write-back, the ALU/MEM forwarding paths and the 2-bit forwarding selects that the register/decode stage consumes.
- Holds the EX/MEM and MEM/WB control and data pipeline registers.
- Detects load-use hazards and issues a one-cycle decode stall.

Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register index width
- ZERO_REG, 31, XZR index; never forwarded, never written

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- dec_rn  in  REG_W  decode source register 1 (instr[9:5])
- dec_rm  in  REG_W  decode source register 2 (post-Reg2Loc mux)
- dec_use_rn  in  1  decode instruction reads rn
- dec_use_rm  in  1  decode instruction reads rm
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  REG_W  EX destination register
- ex_regwrite  in  1  EX instruction writes the regfile
- ex_memread  in  1  EX instruction is a load
- ex_alu_result  in  DATA_W  EX ALU output
- mem_read_data  in  DATA_W  data-memory read data for the MEM-stage instruction (combinational)
- flush  in  1  squash the EX instruction (branch redirect)
- fw_sel1, fw_sel2  out  2  forward selects: 2'b01 ALU, 2'b10 MEM, 2'b11 regfile; 2'b00 never driven
- fwd_alu  out  DATA_W  equals ex_alu_result
- fwd_mem  out  DATA_W  MEM-stage result (load data or ALU result)
- stall  out  1  freeze PC/IF-ID, inject EX bubble
- wb_regwrite  out  1  regfile write enable
- wb_reg  out  REG_W  regfile write address
- wb_data  out  DATA_W  regfile write data

Behaviour:
- Reset (async, reset==0):
  - MEM and WB stage valid/regwrite/memread bits cleared; rd and data fields cleared to 0.
  - Outputs: wb_regwrite=0, wb_reg=0, wb_data=0, stall=0, fw_sel1=fw_sel2=2'b11.
- Stage advance every rising edge; the unit never stalls itself:
  - MEM capture is {ex_rd, ex_regwrite&ex_valid&~flush, ex_memread&ex_valid&~flush, ex_alu_result}.
  - WB capture is {mem_rd, mem_regwrite, fwd_mem}.
- fwd_mem = mem_memread ? mem_read_data : mem_alu_result.
- wb_* are registered outputs, one cycle after MEM.
- wb_regwrite is forced to 0 when wb_reg==ZERO_REG.
- The regfile writes on the falling edge, so WB→decode needs no forwarding path.
- Forwarding (combinational), per source s in {rn, rm}:
  - ex_hit = ex_valid & ex_regwrite & ~ex_memread & ~flush & ex_rd==s & s!=ZERO_REG
  - mem_hit = mem_regwrite & mem_rd==s & s!=ZERO_REG
  - sel = ex_hit ? 01 : mem_hit ? 10 : 11. EX is newer, so EX wins when both hit.
- Load-use stall (combinational):
  - stall = ex_valid & ex_memread & ex_regwrite & ~flush & ex_rd!=ZERO_REG & ((dec_use_rn & ex_rd==dec_rn) | (dec_use_rm & ex_rd==dec_rm)).
  - On the next cycle the load is in MEM, so the same decode instruction sees sel=10 and stall deasserts.
  - Stall is exactly 1 cycle per load-use pair.
- Boundary cases:
  - dec_use_*=0: that source's sel is still computed; only stall ignores it.
  - flush and stall in the same cycle: flush wins, stall=0, and the EX instruction enters MEM as a bubble.
  - Back-to-back writes to the same rd: the youngest matching stage is forwarded.
  - Reset asserted mid-operation: in-flight MEM/WB writes are discarded, with no partial write.

Optional Feature:
- Macro WBFWD_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_count [31:0] and fwd_count [31:0].
  - stall_count increments each cycle stall=1.
  - fwd_count increments by the number of non-regfile selects (0..2) each cycle.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pipe_pkg:
  - typedef fw_sel_t with constants FW_ALU=2'b01, FW_MEM=2'b10, FW_REG=2'b11
  - ZERO_REG
  - struct mem_stage_t {rd, regwrite, memread, alu_result}
- One sub-module: fwd_select, a combinational per-source hit/priority encoder, instantiated twice (rn, rm).

Test Plan:
- Reset: hold reset=0 with random inputs → wb_regwrite=0, stall=0, fw_sel1=fw_sel2=11. Release → the first WB write appears no earlier than 2 cycles after the first valid EX.
- ALU chain: EX writes X3 (result 0x55), decode reads rn=X3 → fw_sel1=01, fwd_alu=0x55. Next cycle, with X3 in MEM → fw_sel1=10, fwd_mem=0x55.
- Load-use: EX is a load to X5, decode rm=X5 with dec_use_rm=1 → stall=1 for 1 cycle. Next cycle: fw_sel2=10, fwd_mem=mem_read_data (0xDEAD), stall=0. One cycle later: wb_reg=5, wb_data=0xDEAD, wb_regwrite=1.
- Priority: EX and MEM both write X7 (0x1, 0x2), decode rn=rm=X7 → both sels=01.
- Zero register: EX writes X31, decode rn=X31 → sel=11 and stall=0; when X31 reaches WB, wb_regwrite=0.
- Flush: EX is a load to X9 and decode reads X9, with flush=1 → stall=0, sel=11. Next cycle MEM mem_regwrite=0, and no write-back occurs.

Source files
------------

// File: rtl/writeback_forward_unit_pkg.sv
// Shared pipeline types for the decode-stage feedback path: forward selects,
// the zero-register index and the EX/MEM and MEM/WB stage records.
package cpu_pipe_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // XZR reads as zero, so it is never forwarded and never written back.
  localparam reg_idx_t ZERO_REG = reg_idx_t'(31);

  typedef enum logic [1:0] {
    FW_ALU = 2'b01,
    FW_MEM = 2'b10,
    FW_REG = 2'b11
  } fw_sel_t;

  typedef struct packed {
    reg_idx_t rd;
    logic     regwrite;
    logic     memread;
    data_t    alu_result;
  } mem_stage_t;

  typedef struct packed {
    reg_idx_t rd;
    logic     regwrite;
    data_t    data;
  } wb_stage_t;

  function automatic logic is_zero_reg(input reg_idx_t r);
    return r == ZERO_REG;
  endfunction

endpackage

// File: rtl/writeback_forward_unit_if.sv
// Bundle between the decode/EX stages and the write-back/forwarding unit.
// WBFWD_PERF_CNT_EN adds the stall/forward event counters.
interface writeback_forward_unit_if;
  import cpu_pipe_pkg::*;

  reg_idx_t dec_rn;
  reg_idx_t dec_rm;
  logic     dec_use_rn;
  logic     dec_use_rm;
  logic     ex_valid;
  reg_idx_t ex_rd;
  logic     ex_regwrite;
  logic     ex_memread;
  data_t    ex_alu_result;
  data_t    mem_read_data;
  logic     flush;

  fw_sel_t  fw_sel1;
  fw_sel_t  fw_sel2;
  data_t    fwd_alu;
  data_t    fwd_mem;
  logic     stall;
  logic     wb_regwrite;
  reg_idx_t wb_reg;
  data_t    wb_data;
`ifdef WBFWD_PERF_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] fwd_count;
`endif

  modport slave (
    input  dec_rn, dec_rm, dec_use_rn, dec_use_rm,
    input  ex_valid, ex_rd, ex_regwrite, ex_memread, ex_alu_result,
    input  mem_read_data, flush,
    output fw_sel1, fw_sel2, fwd_alu, fwd_mem, stall,
    output wb_regwrite, wb_reg, wb_data
`ifdef WBFWD_PERF_CNT_EN
    , output stall_count, fwd_count
`endif
  );

  modport master (
    output dec_rn, dec_rm, dec_use_rn, dec_use_rm,
    output ex_valid, ex_rd, ex_regwrite, ex_memread, ex_alu_result,
    output mem_read_data, flush,
    input  fw_sel1, fw_sel2, fwd_alu, fwd_mem, stall,
    input  wb_regwrite, wb_reg, wb_data
`ifdef WBFWD_PERF_CNT_EN
    , input stall_count, fwd_count
`endif
  );

endinterface

// File: rtl/writeback_forward_unit_fwd_select.sv
// Per-source forwarding priority encoder: the EX result is newer than MEM,
// so an EX hit wins; loads in EX cannot forward (their data is not ready).
module fwd_select
  import cpu_pipe_pkg::*;
(
  input  reg_idx_t src_i,
  input  logic     ex_valid_i,
  input  logic     ex_regwrite_i,
  input  logic     ex_memread_i,
  input  logic     flush_i,
  input  reg_idx_t ex_rd_i,
  input  logic     mem_regwrite_i,
  input  reg_idx_t mem_rd_i,
  output fw_sel_t  sel_o
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = ex_valid_i & ex_regwrite_i & ~ex_memread_i & ~flush_i &
              (ex_rd_i == src_i) & ~is_zero_reg(src_i);
    mem_hit = mem_regwrite_i & (mem_rd_i == src_i) & ~is_zero_reg(src_i);

    if (ex_hit)       sel_o = FW_ALU;
    else if (mem_hit) sel_o = FW_MEM;
    else              sel_o = FW_REG;
  end

endmodule

// File: rtl/writeback_forward_unit.sv
// EX/MEM and MEM/WB pipeline registers, forwarding selects and load-use stall.
// Optional counters are built when WBFWD_PERF_CNT_EN is defined.
module writeback_forward_unit
  import cpu_pipe_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  writeback_forward_unit_if.slave   bus
);

  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d,  wb_q;
  fw_sel_t    sel_rn, sel_rm;
  data_t      fwd_mem;
  logic       ex_live;
  logic       load_use;

  // A flushed EX instruction still advances, but as a bubble.
  assign ex_live = bus.ex_valid & ~bus.flush;

  assign fwd_mem = mem_q.memread ? bus.mem_read_data : mem_q.alu_result;

  // NOTE: every combinationally assigned field gets a value on every path, so no latch is inferred.
  always_comb begin
    mem_d.rd         = bus.ex_rd;
    mem_d.regwrite   = bus.ex_regwrite & ex_live;
    mem_d.memread    = bus.ex_memread  & ex_live;
    mem_d.alu_result = bus.ex_alu_result;

    wb_d.rd       = mem_q.rd;
    wb_d.regwrite = mem_q.regwrite & ~is_zero_reg(mem_q.rd);
    wb_d.data     = fwd_mem;
  end

  // NOTE: the pipeline registers are reset in full so an in-flight write can never
  // leak out after reset; state updates use non-blocking assignment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  fwd_select u_fwd_rn (
    .src_i          (bus.dec_rn),
    .ex_valid_i     (bus.ex_valid),
    .ex_regwrite_i  (bus.ex_regwrite),
    .ex_memread_i   (bus.ex_memread),
    .flush_i        (bus.flush),
    .ex_rd_i        (bus.ex_rd),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_rd_i       (mem_q.rd),
    .sel_o          (sel_rn)
  );

  fwd_select u_fwd_rm (
    .src_i          (bus.dec_rm),
    .ex_valid_i     (bus.ex_valid),
    .ex_regwrite_i  (bus.ex_regwrite),
    .ex_memread_i   (bus.ex_memread),
    .flush_i        (bus.flush),
    .ex_rd_i        (bus.ex_rd),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_rd_i       (mem_q.rd),
    .sel_o          (sel_rm)
  );

  // One-cycle bubble: next cycle the load sits in MEM and forwards via FW_MEM.
  assign load_use = ex_live & bus.ex_memread & bus.ex_regwrite &
                    ~is_zero_reg(bus.ex_rd) &
                    ((bus.dec_use_rn & (bus.ex_rd == bus.dec_rn)) |
                     (bus.dec_use_rm & (bus.ex_rd == bus.dec_rm)));

  // Held in reset, decode must see regfile selects and no stall.
  assign bus.fw_sel1     = reset ? sel_rn : FW_REG;
  assign bus.fw_sel2     = reset ? sel_rm : FW_REG;
  assign bus.stall       = reset & load_use;
  assign bus.fwd_alu     = bus.ex_alu_result;
  assign bus.fwd_mem     = fwd_mem;
  assign bus.wb_regwrite = wb_q.regwrite;
  assign bus.wb_reg      = wb_q.rd;
  assign bus.wb_data     = wb_q.data;

`ifdef WBFWD_PERF_CNT_EN
  logic [31:0] stall_count_d, stall_count_q;
  logic [31:0] fwd_count_d,   fwd_count_q;
  logic [31:0] fwd_inc;

  always_comb begin
    fwd_inc = 32'((bus.fw_sel1 != FW_REG) ? 1 : 0) +
              32'((bus.fw_sel2 != FW_REG) ? 1 : 0);

    stall_count_d = stall_count_q;
    if (bus.stall && stall_count_q != 32'hFFFF_FFFF)
      stall_count_d = stall_count_q + 32'd1;

    if (fwd_count_q > 32'hFFFF_FFFF - fwd_inc) fwd_count_d = 32'hFFFF_FFFF;
    else                                       fwd_count_d = fwd_count_q + fwd_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
  assign bus.fwd_count   = fwd_count_q;
`endif

endmodule

// File: tb/tb_writeback_forward_unit.sv
// Directed bench for writeback_forward_unit: reset, ALU/load forwarding,
// load-use stall, priority, zero register, flush and mid-run reset.
module tb_writeback_forward_unit;
  import cpu_pipe_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  writeback_forward_unit_if bus ();

  writeback_forward_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic [63:0] res);
    bus.ex_valid      = v;
    bus.ex_rd         = rd;
    bus.ex_regwrite   = rw;
    bus.ex_memread    = mr;
    bus.ex_alu_result = res;
  endtask

  task automatic set_dec(input logic [4:0] rn, input logic urn,
                         input logic [4:0] rm, input logic urm);
    bus.dec_rn     = rn;
    bus.dec_use_rn = urn;
    bus.dec_rm     = rm;
    bus.dec_use_rm = urm;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    bus.flush         = 1'b0;
    bus.mem_read_data = 64'hBAD0_BAD0;

    // Reset held with a load-use pattern and random data on the inputs.
    reset = 1'b0;
    set_ex(1'b1, 5'd4, 1'b1, 1'b1, {$urandom, $urandom});
    set_dec(5'd4, 1'b1, 5'($urandom_range(0, 30)), 1'b1);
    bus.mem_read_data = {$urandom, $urandom};
    tick();
    tick();
    check("rst_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);
    check("rst_wb_reg",      64'(bus.wb_reg),      64'd0);
    check("rst_wb_data",     bus.wb_data,          64'd0);
    check("rst_stall",       64'(bus.stall),       64'd0);
    check("rst_sel1",        64'(bus.fw_sel1),     64'(FW_REG));
    check("rst_sel2",        64'(bus.fw_sel2),     64'(FW_REG));

    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0);
    set_dec(5'd0, 1'b0, 5'd0, 1'b0);
    bus.mem_read_data = 64'hBAD0_BAD0;
    reset = 1'b1;
    tick();
    check("post_rst_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);

    // ALU chain: X3 = 0x55 in EX, decode reads X3 on rn.
    set_ex(1'b1, 5'd3, 1'b1, 1'b0, 64'h55);
    set_dec(5'd3, 1'b1, 5'd10, 1'b1);
    #1;
    check("alu_ex_sel1",  64'(bus.fw_sel1), 64'(FW_ALU));
    check("alu_ex_sel2",  64'(bus.fw_sel2), 64'(FW_REG));
    check("alu_fwd_alu",  bus.fwd_alu,      64'h55);
    check("alu_ex_stall", 64'(bus.stall),   64'd0);
    bus.dec_use_rn = 1'b0;
    #1;
    check("alu_nouse_sel1", 64'(bus.fw_sel1), 64'(FW_ALU));
    bus.dec_use_rn = 1'b1;
    tick();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0);
    #1;
    check("alu_mem_sel1",    64'(bus.fw_sel1),     64'(FW_MEM));
    check("alu_fwd_mem",     bus.fwd_mem,          64'h55);
    check("alu_wb_too_soon", 64'(bus.wb_regwrite), 64'd0);
    tick();
    check("alu_wb_regwrite", 64'(bus.wb_regwrite), 64'd1);
    check("alu_wb_reg",      64'(bus.wb_reg),      64'd3);
    check("alu_wb_data",     bus.wb_data,          64'h55);
    check("alu_wb_sel1",     64'(bus.fw_sel1),     64'(FW_REG));

    // Load-use: load to X5 in EX, decode reads X5 on rm.
    set_ex(1'b1, 5'd5, 1'b1, 1'b1, 64'h1234);
    set_dec(5'd2, 1'b1, 5'd5, 1'b0);
    #1;
    check("lu_nouse_stall", 64'(bus.stall),   64'd0);
    bus.dec_use_rm = 1'b1;
    #1;
    check("lu_stall",    64'(bus.stall),   64'd1);
    check("lu_ex_sel2",  64'(bus.fw_sel2), 64'(FW_REG));
    tick();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0);
    bus.mem_read_data = 64'hDEAD;
    #1;
    check("lu_mem_stall", 64'(bus.stall),   64'd0);
    check("lu_mem_sel2",  64'(bus.fw_sel2), 64'(FW_MEM));
    check("lu_fwd_mem",   bus.fwd_mem,      64'hDEAD);
    tick();
    bus.mem_read_data = 64'hBAD0_BAD0;
    check("lu_wb_regwrite", 64'(bus.wb_regwrite), 64'd1);
    check("lu_wb_reg",      64'(bus.wb_reg),      64'd5);
    check("lu_wb_data",     bus.wb_data,          64'hDEAD);

    // Priority: older X7=0x2 in MEM, newer X7=0x1 in EX.
    set_ex(1'b1, 5'd7, 1'b1, 1'b0, 64'h2);
    set_dec(5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_ex(1'b1, 5'd7, 1'b1, 1'b0, 64'h1);
    set_dec(5'd7, 1'b1, 5'd7, 1'b1);
    #1;
    check("pri_sel1",    64'(bus.fw_sel1), 64'(FW_ALU));
    check("pri_sel2",    64'(bus.fw_sel2), 64'(FW_ALU));
    check("pri_fwd_alu", bus.fwd_alu,      64'h1);
    check("pri_fwd_mem", bus.fwd_mem,      64'h2);
    tick();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0);
    #1;
    check("pri_mem_sel1", 64'(bus.fw_sel1), 64'(FW_MEM));
    check("pri_mem_fwd",  bus.fwd_mem,      64'h1);
    check("pri_wb_reg",   64'(bus.wb_reg),  64'd7);
    check("pri_wb_data",  bus.wb_data,      64'h2);

    // Zero register: X31 is never forwarded, stalled on or written.
    tick();
    set_ex(1'b1, 5'd31, 1'b1, 1'b0, 64'h99);
    set_dec(5'd31, 1'b1, 5'd0, 1'b0);
    #1;
    check("xzr_ex_sel1",  64'(bus.fw_sel1), 64'(FW_REG));
    check("xzr_ex_stall", 64'(bus.stall),   64'd0);
    tick();
    set_ex(1'b1, 5'd31, 1'b1, 1'b1, 64'h40);
    set_dec(5'd31, 1'b1, 5'd31, 1'b1);
    #1;
    check("xzr_mem_sel1",   64'(bus.fw_sel1), 64'(FW_REG));
    check("xzr_load_stall", 64'(bus.stall),   64'd0);
    tick();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0);
    set_dec(5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("xzr_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);
    check("xzr_wb_reg",      64'(bus.wb_reg),      64'd31);

    // Flush beats stall; the squashed load becomes a bubble.
    tick();
    set_ex(1'b1, 5'd9, 1'b1, 1'b1, 64'h80);
    set_dec(5'd9, 1'b1, 5'd9, 1'b1);
    bus.flush = 1'b1;
    #1;
    check("fl_stall", 64'(bus.stall),   64'd0);
    check("fl_sel1",  64'(bus.fw_sel1), 64'(FW_REG));
    tick();
    bus.flush = 1'b0;
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0);
    #1;
    check("fl_mem_sel1", 64'(bus.fw_sel1), 64'(FW_REG));
    tick();
    check("fl_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);

    // Reset mid-operation discards in-flight MEM/WB writes.
    set_ex(1'b1, 5'd12, 1'b1, 1'b0, 64'hAB);
    set_dec(5'd12, 1'b1, 5'd0, 1'b0);
    tick();
    set_ex(1'b1, 5'd13, 1'b1, 1'b0, 64'hCD);
    reset = 1'b0;
    #1;
    check("mid_rst_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);
    check("mid_rst_wb_data",     bus.wb_data,          64'd0);
    check("mid_rst_sel1",        64'(bus.fw_sel1),     64'(FW_REG));
    tick();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 64'd0);
    reset = 1'b1;
    #1;
    check("mid_rel_sel1", 64'(bus.fw_sel1), 64'(FW_REG));
    tick();
    check("mid_rel_wb_regwrite", 64'(bus.wb_regwrite), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
